// File: rtl/i2c_cfg_writer.sv
// Single-shot I2C writer: START, three bytes (addr, sub-addr, data) with ack slots, STOP.
// Every bus action lands on a quarter-period tick boundary; NACKs are recorded but never abort.
module i2c_cfg_writer #(
    parameter int CLK_Freq = 50000000,
    parameter int I2C_Freq = 400000,
    parameter int QDIV     = CLK_Freq / (4 * I2C_Freq)
) (
    input  logic        CLOCK_50,
    input  logic        iRST_N,
    input  logic [23:0] I2C_DATA,
    input  logic        GO,
    output logic        END,
    output logic        ACK,
    output logic        I2C_SCLK,
    inout  wire         I2C_SDAT
);
    localparam int CW = (QDIV > 1) ? $clog2(QDIV) : 1;

    typedef enum logic [2:0] {IDLE, START, BIT, STOP, DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     qtr_q, qtr_d;
    logic [4:0]     slot_q, slot_d;
    logic [23:0]    sr_q, sr_d;
    logic           scl_q, scl_d;
    logic           oe_q, oe_d;
    logic           end_q, end_d;
    logic           ack_q, ack_d;
    logic           tick;
    logic           ack_slot, next_ack_slot;

    assign tick          = (cnt_q == CW'(QDIV - 1));
    assign ack_slot      = (slot_q == 5'd8)  || (slot_q == 5'd17) || (slot_q == 5'd26);
    assign next_ack_slot = (slot_q == 5'd7)  || (slot_q == 5'd16) || (slot_q == 5'd25);

    always_ff @(posedge CLOCK_50) begin
        if (!iRST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            qtr_q   <= '0;
            slot_q  <= '0;
            sr_q    <= '0;
            scl_q   <= 1'b1;
            oe_q    <= 1'b0;
            end_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            qtr_q   <= qtr_d;
            slot_q  <= slot_d;
            sr_q    <= sr_d;
            scl_q   <= scl_d;
            oe_q    <= oe_d;
            end_q   <= end_d;
            ack_q   <= ack_d;
        end
    end

    // Each case arm applies the action of the quarter being entered on this tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        qtr_d   = qtr_q;
        slot_d  = slot_q;
        sr_d    = sr_q;
        scl_d   = scl_q;
        oe_d    = oe_q;
        end_d   = end_q;
        ack_d   = ack_q;

        if (state_q != IDLE) cnt_d = tick ? '0 : cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                scl_d = 1'b1;
                oe_d  = 1'b0;
                cnt_d = '0;
                qtr_d = '0;
                if (GO) begin
                    sr_d    = I2C_DATA;
                    end_d   = 1'b0;
                    ack_d   = 1'b0;
                    oe_d    = 1'b1;
                    state_d = START;
                end
            end
            START: if (tick) begin
                qtr_d = qtr_q + 2'd1;
                if (qtr_q == 2'd1) scl_d = 1'b0;
                if (qtr_q == 2'd3) begin
                    state_d = BIT;
                    slot_d  = '0;
                    oe_d    = ~sr_q[23];
                end
            end
            BIT: if (tick) begin
                qtr_d = qtr_q + 2'd1;
                case (qtr_q)
                    2'd0: scl_d = 1'b1;
                    2'd1: if (ack_slot) ack_d = ack_q | I2C_SDAT;
                    2'd2: begin
                        scl_d = 1'b0;
                        if (!ack_slot) sr_d = {sr_q[22:0], 1'b0};
                    end
                    default: begin
                        if (slot_q == 5'd26) begin
                            state_d = STOP;
                            oe_d    = 1'b1;
                        end else begin
                            slot_d = slot_q + 5'd1;
                            oe_d   = next_ack_slot ? 1'b0 : ~sr_q[23];
                        end
                    end
                endcase
            end
            STOP: if (tick) begin
                qtr_d = qtr_q + 2'd1;
                if (qtr_q == 2'd0) scl_d = 1'b1;
                if (qtr_q == 2'd1) oe_d = 1'b0;
                if (qtr_q == 2'd3) state_d = DONE;
            end
            DONE: begin
                end_d = 1'b1;
                if (!GO) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign END      = end_q;
    assign ACK      = ack_q;
    assign I2C_SCLK = scl_q;
    assign I2C_SDAT = oe_q ? 1'b0 : 1'bz;
endmodule

// File: doc/i2c_cfg_writer.md
I2C_CFG_WRITER -- requirements
Module: i2c_cfg_writer

Interface
REQ-001 Parameter CLK_Freq, default 50000000, system clock frequency in Hz.
REQ-002 Parameter I2C_Freq, default 400000, target SCL frequency in Hz.
REQ-003 Parameter QDIV, default CLK_Freq/(4*I2C_Freq) (=31), CLOCK_50 cycles per SCL quarter-period tick.
REQ-004 CLOCK_50  input  1  single system clock; all logic on its rising edge.
REQ-005 iRST_N  input  1  synchronous, active-low reset, sampled on the CLOCK_50 rising edge.
REQ-006 I2C_DATA  input  24  transfer payload: [23:16] slave address+R/W, [15:8] sub-address, [7:0] data.
REQ-007 GO  input  1  level request to start one 3-byte write.
REQ-008 END  output  1  high when the transfer is complete; low while a transfer is in progress.
REQ-009 ACK  output  1  error flag, 1 = at least one byte NACKed by the slave, 0 = all three bytes acknowledged.
REQ-010 I2C_SCLK  output  1  I2C clock, push-pull, 1 when idle.
REQ-011 I2C_SDAT  inout  1  I2C data, open-drain: drives 0 or high-Z only, never drives 1.

Function
REQ-012 A tick counter SHALL count 0..QDIV-1 and emit a one-cycle tick at QDIV-1; the counter SHALL run only outside IDLE and SHALL clear on entry to START.
REQ-013 State machine states SHALL be IDLE, START, BIT, STOP and DONE.
REQ-014 IDLE: SCLK=1, SDAT=Z. If GO=1, I2C_DATA SHALL be latched into a 24-bit shift register, END and ACK SHALL clear, and the state SHALL move to START on the next cycle.
REQ-015 START (4 ticks): SDAT=0 at tick 0 with SCLK=1, SCLK=0 at tick 2, then BIT.
REQ-016 BIT SHALL run 27 slots of 4 ticks each (3 bytes x (8 data bits MSB-first + 1 ack slot)), with slot index 0..26.
REQ-017 In each data slot: q0 drives SDAT to 0 or Z per the shift-register MSB, q1 sets SCLK=1, q3 sets SCLK=0 and shifts the register left by one.
REQ-018 In each ack slot (indices 8, 17, 26): q0 releases SDAT, q1 sets SCLK=1, q2 samples SDAT and ORs (SDAT==1) into ACK, q3 sets SCLK=0.
REQ-019 After slot 26, the state SHALL enter STOP.
REQ-020 A NACK SHALL NOT abort the transfer: all 27 slots and the STOP condition SHALL always complete.
REQ-021 STOP (4 ticks): SDAT=0 at q0, SCLK=1 at q1, SDAT=Z at q2, then DONE.
REQ-022 DONE: END=1 and ACK SHALL hold their values; the state SHALL return to IDLE only when GO=0, and END SHALL stay 1 in IDLE until the next start.
REQ-023 GO held high after completion SHALL NOT start a second transfer; a new transfer requires GO low for at least one cycle, then high.
REQ-024 GO deasserted mid-transfer SHALL be ignored, and changes on I2C_DATA after the latch SHALL have no effect.
REQ-025 SDA transitions SHALL occur only while SCLK=0, except at START and STOP.
REQ-026 A full transfer SHALL take 116 ticks; END SHALL rise 116*QDIV+2 cycles (±1) after the cycle in which GO is sampled high in IDLE.

Reset
REQ-027 When iRST_N=0 at a clock edge, the block SHALL be in IDLE on that edge with SCLK=1, SDAT=Z, END=0, ACK=0, tick counter=0 and shift register=0.
REQ-028 A reset mid-transfer SHALL abandon the bus immediately with no STOP generated; the block SHALL accept GO on the first cycle after iRST_N returns high.

Verification
REQ-029 Bench SHALL cover: I2C_DATA=0x341E00, slave model ACKs all bytes -> SDA bits 0x34,0x1E,0x00 MSB-first, END=1, ACK=0.
REQ-030 Bench SHALL cover: slave NACKs the address byte only -> all 27 slots plus STOP still clocked, END=1, ACK=1.
REQ-031 Bench SHALL cover: QDIV=31 -> SCL high and low each 62 cycles, END rises at 116*31+2 cycles (±1) after GO.
REQ-032 Bench SHALL cover: GO held high 500 cycles past END -> no new START; GO 0 then 1 -> second transfer runs.
REQ-033 Bench SHALL cover: iRST_N=0 during slot 12 -> next edge SCLK=1, SDAT=Z, END=0, ACK=0; a new GO then completes normally.
REQ-034 Bench SHALL cover: 10 back-to-back transfers with GO set, END awaited, GO cleared, 1-cycle gap -> every transfer framed by START/STOP, and no SDA change while SCL=1 outside START/STOP.
